// File: rtl/iiitb_sdm_pkg.sv
// Shared constants and types for the time-shared sequence detector.
package iiitb_sdm_pkg;

    localparam int DEF_NCH     = 4;
    localparam int DEF_PAT_LEN = 5;
    localparam int DEF_CNT_W   = 8;
    localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 5'b10101;

    localparam int CH_W   = (DEF_NCH > 1) ? $clog2(DEF_NCH) : 1;
    localparam int FILL_W = $clog2(DEF_PAT_LEN + 1);

    typedef logic [CH_W-1:0] chan_t;

endpackage

// File: rtl/iiitb_sdm_step.sv
// Shared combinational detection step: shift one bit into a channel history.
module iiitb_sdm_step
    import iiitb_sdm_pkg::*;
#(
    parameter int                  PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0]  PATTERN = DEF_PATTERN,
    parameter int                  FW      = $clog2(PAT_LEN + 1)
) (
    input  logic [PAT_LEN-1:0] hist,
    input  logic [FW-1:0]      fill,
    input  logic               din,
    output logic [PAT_LEN-1:0] next_hist,
    output logic [FW-1:0]      next_fill,
    output logic               hit
);

    always_comb begin
        next_hist = {hist[PAT_LEN-2:0], din};
        next_fill = (fill >= FW'(PAT_LEN)) ? FW'(PAT_LEN) : fill + FW'(1);
        // the fill gate keeps reset-zero history from matching
        hit = (next_hist == PATTERN) && (next_fill == FW'(PAT_LEN));
    end

endmodule

// File: rtl/iiitb_sdm_arb.sv
// Round-robin arbiter sharing one sequence-detect step across NCH channels.
module iiitb_sdm_arb
    import iiitb_sdm_pkg::*;
#(
    parameter int                 NCH     = DEF_NCH,
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
    parameter int                 CNT_W   = DEF_CNT_W,
    parameter int                 CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [NCH-1:0]   ch_valid,
    input  logic [NCH-1:0]   ch_bit,
    output logic [NCH-1:0]   ch_ready,
    output logic             match_valid,
    output logic [CW-1:0]    match_chan,
    input  logic [CW-1:0]    cnt_sel,
    output logic [CNT_W-1:0] match_cnt,
    input  logic             clr_cnt,
    output logic             io_oeb
);

    localparam int FW = $clog2(PAT_LEN + 1);

    logic [PAT_LEN-1:0] hist [NCH];
    logic [FW-1:0]      fill [NCH];
    logic [CNT_W-1:0]   cnt  [NCH];
    logic [CW-1:0]      rr;

    logic               found;
    logic [CW-1:0]      g;
    logic [PAT_LEN-1:0] next_hist;
    logic [FW-1:0]      next_fill;
    logic               hit;

    // search downward so the channel closest to rr is the last to win
    always_comb begin
        found = 1'b0;
        g     = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            int j;
            j = int'(rr) + k;
            if (j >= NCH) j = j - NCH;
            if (en && ch_valid[j]) begin
                found = 1'b1;
                g     = CW'(j);
            end
        end
    end

    always_comb begin
        ch_ready = '0;
        for (int i = 0; i < NCH; i++)
            ch_ready[i] = found && (g == CW'(i));
    end

    iiitb_sdm_step #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN),
        .FW      (FW)
    ) u_step (
        .hist      (hist[g]),
        .fill      (fill[g]),
        .din       (ch_bit[g]),
        .next_hist (next_hist),
        .next_fill (next_fill),
        .hit       (hit)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr          <= '0;
            match_valid <= 1'b0;
            match_chan  <= '0;
            for (int i = 0; i < NCH; i++) begin
                hist[i] <= '0;
                fill[i] <= '0;
            end
        end else begin
            match_valid <= found && hit;
            if (found) begin
                hist[g]    <= next_hist;
                fill[g]    <= next_fill;
                rr         <= (g == CW'(NCH - 1)) ? '0 : g + CW'(1);
                match_chan <= g;
            end
        end
    end

    // clear takes priority over a coincident hit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++)
                cnt[i] <= '0;
        end else if (clr_cnt) begin
            for (int i = 0; i < NCH; i++)
                cnt[i] <= '0;
        end else if (found && hit && (cnt[g] != {CNT_W{1'b1}})) begin
            cnt[g] <= cnt[g] + CNT_W'(1);
        end
    end

    assign match_cnt = (int'(cnt_sel) < NCH) ? cnt[cnt_sel] : '0;
    assign io_oeb    = 1'b0;

endmodule

// File: tb/tb_iiitb_sdm_arb.sv
// Directed self-checking bench for iiitb_sdm_arb.
module tb_iiitb_sdm_arb;

    logic       clock = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] ch_valid;
    logic [3:0] ch_bit;
    logic [3:0] ch_ready;
    logic       match_valid;
    logic [1:0] match_chan;
    logic [1:0] cnt_sel;
    logic [7:0] match_cnt;
    logic       clr_cnt;
    logic       io_oeb;

    logic [3:0] ch_ready2;
    logic       match_valid2;
    logic [1:0] match_chan2;
    logic [7:0] match_cnt2;
    logic       io_oeb2;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    iiitb_sdm_arb dut (
        .clock       (clock),
        .reset       (reset),
        .en          (en),
        .ch_valid    (ch_valid),
        .ch_bit      (ch_bit),
        .ch_ready    (ch_ready),
        .match_valid (match_valid),
        .match_chan  (match_chan),
        .cnt_sel     (cnt_sel),
        .match_cnt   (match_cnt),
        .clr_cnt     (clr_cnt),
        .io_oeb      (io_oeb)
    );

    iiitb_sdm_arb #(.PATTERN(5'b00001)) dut2 (
        .clock       (clock),
        .reset       (reset),
        .en          (en),
        .ch_valid    (ch_valid),
        .ch_bit      (ch_bit),
        .ch_ready    (ch_ready2),
        .match_valid (match_valid2),
        .match_chan  (match_chan2),
        .cnt_sel     (cnt_sel),
        .match_cnt   (match_cnt2),
        .clr_cnt     (clr_cnt),
        .io_oeb      (io_oeb2)
    );

    typedef struct {
        logic       en;
        logic [3:0] valid;
        logic [3:0] bits;
        logic [3:0] ready;
        logic       mv;
        logic [1:0] mc;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        en = 0; ch_valid = 0; ch_bit = 0; clr_cnt = 0; cnt_sel = 0;
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    // drive a single-channel bit; returns match pulse of dut and dut2
    task automatic send(input int ch, input logic b, input logic clr,
                        output logic mv, output logic mv2);
        en = 1;
        ch_valid = 4'b0001 << ch;
        ch_bit = {4{b}};
        clr_cnt = clr;
        tick();
        mv = match_valid;
        mv2 = match_valid2;
        ch_valid = 0;
        clr_cnt = 0;
    endtask

    task automatic add(logic e, logic [3:0] v, logic [3:0] b,
                       logic [3:0] r, logic mv, logic [1:0] mc);
        vec_t t;
        t.en = e; t.valid = v; t.bits = b; t.ready = r; t.mv = mv; t.mc = mc;
        vecs.push_back(t);
    endtask

    initial begin
        logic mv, mv2;
        int pulses;
        logic [4:0] pat;
        pat = 5'b10101;

        do_reset();
        chk("reset_ready", ch_ready, 0);
        chk("reset_mv", match_valid, 0);
        chk("reset_mc", match_chan, 0);
        chk("reset_cnt", match_cnt, 0);
        chk("io_oeb", io_oeb, 0);

        // single channel, overlap, enable gating
        add(1, 4'b0001, 4'b0001, 4'b0001, 0, 0);
        add(1, 4'b0001, 4'b0000, 4'b0001, 0, 0);
        add(1, 4'b0001, 4'b0001, 4'b0001, 0, 0);
        add(1, 4'b0001, 4'b0000, 4'b0001, 0, 0);
        add(1, 4'b0001, 4'b0001, 4'b0001, 1, 0);
        for (int i = 0; i < 9; i++)
            add(1, 4'b0010, (i % 2 == 0) ? 4'b0010 : 4'b0000, 4'b0010,
                (i == 4 || i == 6 || i == 8), 1);
        for (int i = 0; i < 4; i++)
            add(1, 4'b0100, (i % 2 == 0) ? 4'b0100 : 4'b0000, 4'b0100, 0, 2);
        add(0, 4'b0100, 4'b0100, 4'b0000, 0, 2);
        add(0, 4'b1111, 4'b1111, 4'b0000, 0, 2);
        add(1, 4'b0100, 4'b0100, 4'b0100, 1, 2);

        foreach (vecs[i]) begin
            en = vecs[i].en;
            ch_valid = vecs[i].valid;
            ch_bit = vecs[i].bits;
            #1;
            chk($sformatf("vec%0d_ready", i), ch_ready, vecs[i].ready);
            tick();
            chk($sformatf("vec%0d_mv", i), match_valid, vecs[i].mv);
            if (vecs[i].mv)
                chk($sformatf("vec%0d_mc", i), match_chan, vecs[i].mc);
        end
        en = 0; ch_valid = 0;
        for (int c = 0; c < 4; c++) begin
            cnt_sel = 2'(c);
            #1;
            chk($sformatf("tbl_cnt%0d", c), match_cnt, (c == 0) ? 1 :
                (c == 1) ? 3 : (c == 2) ? 1 : 0);
        end

        // interleave: all valid, grants rotate 0..3
        do_reset();
        en = 1;
        ch_valid = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            ch_bit = {4{pat[4 - c / 4]}};
            #1;
            chk($sformatf("rr%0d_ready", c), ch_ready, 4'b0001 << (c % 4));
            tick();
            chk($sformatf("rr%0d_mv", c), match_valid, c >= 16);
            if (c >= 16)
                chk($sformatf("rr%0d_mc", c), match_chan, c % 4);
        end
        en = 0; ch_valid = 0;
        for (int c = 0; c < 4; c++) begin
            cnt_sel = 2'(c);
            #1;
            chk($sformatf("rr_cnt%0d", c), match_cnt, 1);
        end

        // fill gate on the 00001 build
        do_reset();
        send(0, 1, 0, mv, mv2);
        chk("gate_single1", mv2, 0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            send(0, (i == 4), 0, mv, mv2);
            pulses += int'(mv2);
        end
        chk("gate_last_mv", mv2, 1);
        chk("gate_pulses", pulses, 1);

        // saturation then clear coinciding with a hit
        do_reset();
        pulses = 0;
        for (int i = 0; i < 603; i++) begin
            send(2, (i % 2 == 0), 0, mv, mv2);
            pulses += int'(mv);
        end
        chk("sat_pulses", pulses, 300);
        cnt_sel = 2;
        #1;
        chk("sat_cnt", match_cnt, 255);
        send(2, 0, 0, mv, mv2);
        send(2, 1, 1, mv, mv2);
        chk("clr_hit_mv", mv, 1);
        chk("clr_hit_cnt", match_cnt, 0);

        // reset mid-stream discards partial pattern
        do_reset();
        for (int i = 0; i < 4; i++)
            send(3, (i % 2 == 0), 0, mv, mv2);
        reset = 1;
        #1;
        chk("rst_mid_ready", ch_ready, 0);
        chk("rst_mid_mv", match_valid, 0);
        chk("rst_mid_mc", match_chan, 0);
        tick();
        reset = 0;
        send(3, 1, 0, mv, mv2);
        chk("rst_single1", mv, 0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            send(3, pat[4 - i], 0, mv, mv2);
            pulses += int'(mv);
        end
        chk("rst_full_mv", mv, 1);
        chk("rst_full_mc", match_chan, 3);
        chk("rst_full_pulses", pulses, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
